// File: rtl/rd_stream_pkg.sv
// ---------------------------------------------------------------------------
// rd_stream_pkg
// Shared definitions for the per-port SRAM read streamer:
//   - streamState_e : descriptor engine states (IDLE / FETCH / DRAIN)
//   - TAG_BITS      : number of framing tag bits carried beside each data word
//   - entryWidth()  : skid FIFO entry width for a given data width (DATA_WIDTH+2)
//   - sopBit/eopBit : position of the framing tags inside a FIFO entry
// A FIFO entry is laid out as {sop_tag, eop_tag, data[DATA_WIDTH-1:0]}.
// ---------------------------------------------------------------------------
package rd_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } streamState_e;

  localparam int unsigned TAG_BITS = 2;

  // Width of one skid FIFO entry: the data word plus the two framing tags.
  function automatic int unsigned entryWidth(input int unsigned dataWidth);
    return dataWidth + TAG_BITS;
  endfunction

  // The eop tag sits directly above the data word.
  function automatic int unsigned eopBit(input int unsigned dataWidth);
    return dataWidth;
  endfunction

  // The sop tag is the most significant bit of the entry.
  function automatic int unsigned sopBit(input int unsigned dataWidth);
    return dataWidth + 1;
  endfunction

endpackage

// File: rtl/rd_skid_fifo.sv
// ---------------------------------------------------------------------------
// rd_skid_fifo
// Small synchronous FIFO that absorbs the SRAM read latency and downstream
// backpressure for one read port. The head entry is taken straight from the
// storage registers, so the output has no combinational path from the inputs.
// Push and pop in the same cycle are allowed at every occupancy; a pop while
// empty is ignored.
// Ports:
//   clk         clock
//   rst         asynchronous active-low reset (clears pointers and count)
//   push_i      write pushData_i this cycle
//   pushData_i  entry to write
//   pop_i       consume the head entry this cycle (ignored when empty)
//   headVld_o   FIFO holds at least one entry
//   headData_o  oldest entry
//   count_o     number of entries currently held
// ---------------------------------------------------------------------------
module rd_skid_fifo #(
  parameter int unsigned WIDTH = 66,
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push_i,
  input  logic [WIDTH-1:0]                 pushData_i,
  input  logic                             pop_i,
  output logic                             headVld_o,
  output logic [WIDTH-1:0]                 headData_o,
  output logic [$clog2(DEPTH+1)-1:0]       count_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  // Pointer advance with explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state for pointers and occupancy. When full, a simultaneous push and
  // pop writes into the slot being vacated, which is exactly the slot wrPtr
  // points at, so ordering is preserved.
  always_comb begin
    doPush  = push_i;
    doPop   = pop_i && (count_q != '0);
    wrPtr_d = doPush ? nextPtr(wrPtr_q) : wrPtr_q;
    rdPtr_d = doPop  ? nextPtr(rdPtr_q) : rdPtr_q;
    count_d = count_q;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed once counted as valid.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

  assign headVld_o  = (count_q != '0);
  assign headData_o = mem_q[rdPtr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/rd_port_streamer.sv
// ---------------------------------------------------------------------------
// rd_port_streamer
// Per-output-port SRAM read engine. Accepts one packet descriptor at a time,
// issues sequential read requests through the shared read-port arbiter, and
// streams the returned words out with sop/eop framing under downstream
// backpressure. Requests are credit-limited so the skid FIFO never overflows.
// Optional feature macro: RD_PKT_CNT_EN adds a 16-bit completed-packet counter
// output (pkt_cnt); when undefined the port and counter do not exist.
// Ports:
//   clk, rst         clock; asynchronous active-low reset
//   desc_vld/rdy     descriptor handshake; desc_addr first word, desc_len words
//   rd_req/gnt/addr  read request to the arbiter; SRAM samples rd_addr on grant
//   rd_dout          SRAM read data, valid the cycle after a grant
//   ready            downstream ready for this port
//   rd_vld/sop/eop   output word qualifier and framing
//   rd_data          output word
//   busy             engine active or words still buffered
//   pkt_cnt          (RD_PKT_CNT_EN only) count of delivered eop words
// ---------------------------------------------------------------------------
module rd_port_streamer
  import rd_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  desc_vld,
  input  logic [ADDR_WIDTH-1:0] desc_addr,
  input  logic [LEN_WIDTH-1:0]  desc_len,
  output logic                  desc_rdy,
  output logic                  rd_req,
  input  logic                  rd_gnt,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_dout,
  input  logic                  ready,
  output logic                  rd_sop,
  output logic                  rd_eop,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy
`ifdef RD_PKT_CNT_EN
  ,
  output logic [15:0]           pkt_cnt
`endif
);

  localparam int unsigned ENTRY_W = entryWidth(DATA_WIDTH);
  localparam int unsigned SOP_POS = sopBit(DATA_WIDTH);
  localparam int unsigned EOP_POS = eopBit(DATA_WIDTH);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);

  // With fewer than three entries the credit loop cannot sustain one word per
  // cycle, so such a configuration is refused at elaboration.
  if (FIFO_DEPTH < 3) begin : gDepthCheck
    $error("rd_port_streamer: FIFO_DEPTH must be at least 3");
  end

  streamState_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  firstPending_q, firstPending_d;
  logic                  inflight_q, inflight_d;
  logic                  inflSop_q, inflSop_d;
  logic                  inflEop_q, inflEop_d;

  logic [CNT_W-1:0]      fifoCount;
  logic [CNT_W:0]        creditUsed;
  logic                  haveCredit;
  logic                  descTaken;
  logic                  grantTaken;
  logic                  fifoPop;
  logic                  headVld;
  logic [ENTRY_W-1:0]    pushEntry;
  logic [ENTRY_W-1:0]    headEntry;

  // Words already granted but not yet popped are either in flight from the
  // SRAM or sitting in the FIFO; a new request is only allowed while that
  // total leaves room for one more entry.
  assign creditUsed = {1'b0, fifoCount} + {{CNT_W{1'b0}}, inflight_q};
  assign haveCredit = (creditUsed < (CNT_W + 1)'(FIFO_DEPTH));

  // Descriptor engine: next state plus the handshake outputs it owns.
  always_comb begin
    state_d  = state_q;
    desc_rdy = 1'b0;
    rd_req   = 1'b0;
    case (state_q)
      IDLE: begin
        desc_rdy = 1'b1;
        if (desc_vld && (desc_len != '0)) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        rd_req = haveCredit;
        if (haveCredit && rd_gnt && (remaining_q == LEN_WIDTH'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && (fifoCount == '0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign descTaken  = desc_vld && desc_rdy;
  assign grantTaken = rd_req && rd_gnt;

  // Address/length bookkeeping and the tags that travel with each read. A
  // zero-length descriptor is accepted but changes nothing here.
  always_comb begin
    addr_d         = addr_q;
    remaining_d    = remaining_q;
    firstPending_d = firstPending_q;
    inflight_d     = grantTaken;
    inflSop_d      = inflSop_q;
    inflEop_d      = inflEop_q;
    if (descTaken && (desc_len != '0)) begin
      addr_d         = desc_addr;
      remaining_d    = desc_len;
      firstPending_d = 1'b1;
    end
    if (grantTaken) begin
      addr_d         = addr_q + ADDR_WIDTH'(1);
      remaining_d    = remaining_q - LEN_WIDTH'(1);
      firstPending_d = 1'b0;
      inflSop_d      = firstPending_q;
      inflEop_d      = (remaining_q == LEN_WIDTH'(1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      remaining_q    <= '0;
      firstPending_q <= 1'b0;
      inflight_q     <= 1'b0;
      inflSop_q      <= 1'b0;
      inflEop_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      remaining_q    <= remaining_d;
      firstPending_q <= firstPending_d;
      inflight_q     <= inflight_d;
      inflSop_q      <= inflSop_d;
      inflEop_q      <= inflEop_d;
    end
  end

  // The SRAM answers one cycle after the grant, which is the cycle inflight
  // is set, so the returned word is pushed together with its tags then.
  assign pushEntry = {inflSop_q, inflEop_q, rd_dout};
  assign fifoPop   = headVld && ready;

  rd_skid_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) uSkidFifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (inflight_q),
    .pushData_i (pushEntry),
    .pop_i      (fifoPop),
    .headVld_o  (headVld),
    .headData_o (headEntry),
    .count_o    (fifoCount)
  );

  // Output fields are forced to zero while nothing is valid so that stale
  // FIFO contents never appear on the port.
  assign rd_addr = addr_q;
  assign rd_vld  = headVld;
  assign rd_data = headVld ? headEntry[DATA_WIDTH-1:0] : '0;
  assign rd_sop  = headVld && headEntry[SOP_POS];
  assign rd_eop  = headVld && headEntry[EOP_POS];
  assign busy    = (state_q != IDLE) || (fifoCount != '0);

`ifdef RD_PKT_CNT_EN
  logic [15:0] pktCnt_q;

  // Counts delivered packets; an aborted packet never reaches its eop word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pktCnt_q <= '0;
    end else if (rd_vld && ready && rd_eop) begin
      pktCnt_q <= pktCnt_q + 16'd1;
    end
  end

  assign pkt_cnt = pktCnt_q;
`endif

endmodule

// File: tb/tb_rd_port_streamer.sv
// ---------------------------------------------------------------------------
// tb_rd_port_streamer
// Self-checking bench for rd_port_streamer. The bench plays the SRAM and the
// arbiter: the word at address A is always memFn(A), returned the cycle after
// a grant. Every accepted descriptor is expanded into the list of addresses
// it must request and the framed words it must deliver; the DUT is then
// checked against those lists as it runs.
// ---------------------------------------------------------------------------
module tb_rd_port_streamer;

  localparam int DW = 64;
  localparam int AW = 17;
  localparam int LW = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic          sop;
    logic          eop;
  } expWord_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          desc_vld;
  logic [AW-1:0] desc_addr;
  logic [LW-1:0] desc_len;
  logic          desc_rdy;
  logic          rd_req;
  logic          rd_gnt;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_dout;
  logic          ready;
  logic          rd_sop;
  logic          rd_eop;
  logic          rd_vld;
  logic [DW-1:0] rd_data;
  logic          busy;
`ifdef RD_PKT_CNT_EN
  logic [15:0]   pkt_cnt;
`endif

  // Expected read addresses and expected delivered words, in order.
  logic [AW-1:0] addrQ[$];
  expWord_t      wordQ[$];
  int            grantCyc[$];
  int            outCyc[$];

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            granted = 0;
  int            popped = 0;
  int            pktModel = 0;
  int            acceptCyc = 0;
  bit            lastAccept = 0;
  bit            prevStall = 0;
  logic [DW-1:0] prevData;
  logic          prevSop;
  logic          prevEop;
  int            gntMode = 0;
  int            readyMode = 0;
  bit            gPending = 0;
  logic [AW-1:0] gAddr;

  rd_port_streamer dut (
    .clk       (clk),
    .rst       (rst),
    .desc_vld  (desc_vld),
    .desc_addr (desc_addr),
    .desc_len  (desc_len),
    .desc_rdy  (desc_rdy),
    .rd_req    (rd_req),
    .rd_gnt    (rd_gnt),
    .rd_addr   (rd_addr),
    .rd_dout   (rd_dout),
    .ready     (ready),
    .rd_sop    (rd_sop),
    .rd_eop    (rd_eop),
    .rd_vld    (rd_vld),
    .rd_data   (rd_data),
    .busy      (busy)
`ifdef RD_PKT_CNT_EN
    ,
    .pkt_cnt   (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Hard stop in case something wedges outside every bounded wait.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Contents of the modelled SRAM: distinct, address-derived 64-bit words.
  function automatic logic [DW-1:0] memFn(input logic [AW-1:0] a);
    logic [29:0] low;
    low = {13'd0, a} * 30'd3 + 30'd5;
    return {a, ~a, low};
  endfunction

  // One comparison point; a failure is counted and reported.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives grant and ready for the next cycle according to the current mode.
  task automatic applyStimulus();
    rd_gnt = (gntMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    case (readyMode)
      0:       ready = 1'b1;
      1:       ready = ~ready;
      default: ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // One clock cycle: check the DUT at the falling edge against the model,
  // update the model with this cycle's handshakes, then after the rising edge
  // return SRAM data for a grant (garbage otherwise) and drive new inputs.
  task automatic tick();
    logic [AW-1:0] ea;
    expWord_t      w;
    @(negedge clk);
    lastAccept = 0;
    if (prevStall) begin
      checkOutput("stall_vld", 64'(rd_vld), 64'd1);
      checkOutput("stall_data", rd_data, prevData);
      checkOutput("stall_sop", 64'(rd_sop), 64'(prevSop));
      checkOutput("stall_eop", 64'(rd_eop), 64'(prevEop));
    end
    if (rd_req) begin
      checkOutput("credit", 64'((granted - popped) < 4), 64'd1);
    end
    if (wordQ.size() != 0) begin
      checkOutput("busy_active", 64'(busy), 64'd1);
    end
    gPending = 0;
    if (rd_req && rd_gnt) begin
      if (addrQ.size() == 0) begin
        checkOutput("spurious_req", 64'(rd_req), 64'd0);
      end else begin
        ea = addrQ.pop_front();
        checkOutput("rd_addr", 64'(rd_addr), 64'(ea));
        granted++;
        gPending = 1;
        gAddr = rd_addr;
        grantCyc.push_back(cyc);
      end
    end
    if (rd_vld && ready) begin
      if (wordQ.size() == 0) begin
        checkOutput("spurious_vld", 64'(rd_vld), 64'd0);
      end else begin
        w = wordQ.pop_front();
        checkOutput("rd_data", rd_data, memFn(w.addr));
        checkOutput("rd_sop", 64'(rd_sop), 64'(w.sop));
        checkOutput("rd_eop", 64'(rd_eop), 64'(w.eop));
        popped++;
        if (w.eop) pktModel++;
        outCyc.push_back(cyc);
      end
    end
    if (desc_vld && desc_rdy) begin
      lastAccept = 1;
      acceptCyc = cyc;
      for (int i = 0; i < int'(desc_len); i++) begin
        ea = AW'(int'(desc_addr) + i);
        addrQ.push_back(ea);
        w.addr = ea;
        w.sop = (i == 0);
        w.eop = (i == int'(desc_len) - 1);
        wordQ.push_back(w);
      end
    end
    prevStall = rd_vld && !ready;
    prevData = rd_data;
    prevSop = rd_sop;
    prevEop = rd_eop;
    @(posedge clk);
    cyc++;
    #1;
    rd_dout = gPending ? memFn(gAddr) : {$urandom, $urandom};
    if (lastAccept) desc_vld = 1'b0;
    applyStimulus();
  endtask

  // Offers a descriptor until it is accepted, within a bounded wait.
  task automatic sendDesc(input logic [AW-1:0] a, input logic [LW-1:0] len);
    bit ok;
    ok = 0;
    desc_addr = a;
    desc_len = len;
    desc_vld = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      ok = lastAccept;
    end
    desc_vld = 1'b0;
    checkOutput("desc_accept", 64'(ok), 64'd1);
  endtask

  // Runs until every expected word is out, then lets the engine settle and
  // confirms it is idle and ready for the next descriptor.
  task automatic waitIdle();
    bit done;
    done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      tick();
      done = (wordQ.size() == 0) && (addrQ.size() == 0);
    end
    checkOutput("drain_done", 64'(done), 64'd1);
    tick();
    tick();
    checkOutput("idle_busy", 64'(busy), 64'd0);
    checkOutput("idle_desc_rdy", 64'(desc_rdy), 64'd1);
  endtask

  // Output state expected while reset is held.
  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rd_req"}, 64'(rd_req), 64'd0);
    checkOutput({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    checkOutput({tag, "_rd_vld"}, 64'(rd_vld), 64'd0);
    checkOutput({tag, "_rd_sop"}, 64'(rd_sop), 64'd0);
    checkOutput({tag, "_rd_eop"}, 64'(rd_eop), 64'd0);
    checkOutput({tag, "_rd_data"}, rd_data, 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_desc_rdy"}, 64'(desc_rdy), 64'd1);
  endtask

  // Directed scenarios followed by a randomized mix, all in one sequence.
  initial begin
    int t;
    int startPop;
    bit reached;

    rst = 1'b0;
    desc_vld = 1'b0;
    desc_addr = '0;
    desc_len = '0;
    rd_gnt = 1'b0;
    rd_dout = '0;
    ready = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    checkResetState("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    gntMode = 0;
    readyMode = 0;
    applyStimulus();

    $display("[TB] scenario 1: four words, immediate grant, ready high");
    grantCyc.delete();
    outCyc.delete();
    sendDesc(17'h00010, 8'd4);
    t = acceptCyc;
    waitIdle();
    checkOutput("t1_grant_count", 64'(grantCyc.size()), 64'd4);
    checkOutput("t1_out_count", 64'(outCyc.size()), 64'd4);
    if (grantCyc.size() == 4 && outCyc.size() == 4) begin
      checkOutput("t1_first_req", 64'(grantCyc[0]), 64'(t + 1));
      checkOutput("t1_last_req", 64'(grantCyc[3]), 64'(t + 4));
      checkOutput("t1_first_vld", 64'(outCyc[0]), 64'(t + 3));
      checkOutput("t1_last_vld", 64'(outCyc[3]), 64'(t + 6));
    end

    $display("[TB] scenario 2: single word at top of address space");
    sendDesc(17'h1FFFF, 8'd1);
    waitIdle();
    sendDesc(17'h00100, 8'd2);
    waitIdle();

    $display("[TB] scenario 3: address wrap");
    sendDesc(17'h1FFFE, 8'd3);
    waitIdle();

    $display("[TB] scenario 4: toggling ready, random grant");
    gntMode = 1;
    readyMode = 1;
    sendDesc(AW'($urandom), 8'd8);
    waitIdle();

    $display("[TB] scenario 5: zero-length descriptor");
    gntMode = 0;
    readyMode = 0;
    sendDesc(17'h00055, 8'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("zero_desc_rdy", 64'(desc_rdy), 64'd1);
      checkOutput("zero_rd_req", 64'(rd_req), 64'd0);
      checkOutput("zero_rd_vld", 64'(rd_vld), 64'd0);
      tick();
    end
    sendDesc(17'h00200, 8'd2);
    waitIdle();

    $display("[TB] randomized descriptors");
    for (int n = 0; n < 16; n++) begin
      gntMode = $urandom_range(0, 1);
      readyMode = $urandom_range(0, 2);
      sendDesc(AW'($urandom), LW'($urandom_range(0, 20)));
      if (n % 4 == 3) waitIdle();
    end
    waitIdle();

    $display("[TB] scenario 6: reset in the middle of a packet");
    gntMode = 0;
    readyMode = 0;
`ifdef RD_PKT_CNT_EN
    checkOutput("pkt_cnt_before_abort", 64'(pkt_cnt), 64'(pktModel));
`endif
    sendDesc(17'h00300, 8'd6);
    startPop = popped;
    reached = 0;
    for (int i = 0; i < 50 && !reached; i++) begin
      tick();
      reached = (popped - startPop) >= 2;
    end
    checkOutput("abort_point", 64'(reached), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    checkResetState("abort");
`ifdef RD_PKT_CNT_EN
    checkOutput("abort_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif
    addrQ.delete();
    wordQ.delete();
    granted = 0;
    popped = 0;
    pktModel = 0;
    prevStall = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    checkOutput("post_reset_desc_rdy", 64'(desc_rdy), 64'd1);
    sendDesc(17'h00400, 8'd2);
    waitIdle();
`ifdef RD_PKT_CNT_EN
    checkOutput("pkt_cnt_final", 64'(pkt_cnt), 64'(pktModel));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
